// File: rtl/sweep_ctrl.sv
// Frequency-sweep controller: ramps the sine generator's phase increment from lo up to hi,
// dwells at the peak, then ramps back down. The profile runs once or loops until aborted.
module sweep_ctrl #(
    parameter int D_WIDTH = 8,
    parameter int T_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               loop,
    input  logic [D_WIDTH-1:0] incr_lo,
    input  logic [D_WIDTH-1:0] incr_hi,
    input  logic [D_WIDTH-1:0] step,
    input  logic [T_WIDTH-1:0] dwell,
    input  logic [T_WIDTH-1:0] hold,
    output logic [D_WIDTH-1:0] incr,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [D_WIDTH-1:0] incr_n;
    logic               en_n, done_n, latch, expire;
    logic [T_WIDTH-1:0] timer, timer_n;

    logic               loop_r;
    logic [D_WIDTH-1:0] lo_r, hi_r, step_r;
    logic [T_WIDTH-1:0] dwell_r, hold_r;

    logic [D_WIDTH-1:0] s_eff;
    logic [T_WIDTH-1:0] d_last, h_last;
    logic [D_WIDTH:0]   up_sum, down_floor;

    // Zero step/dwell/hold behave as one; sums carry an extra bit so nothing wraps.
    assign s_eff      = (step_r == '0) ? D_WIDTH'(1) : step_r;
    assign d_last     = (dwell_r == '0) ? '0 : dwell_r - T_WIDTH'(1);
    assign h_last     = (hold_r == '0) ? '0 : hold_r - T_WIDTH'(1);
    assign up_sum     = {1'b0, incr} + {1'b0, s_eff};
    assign down_floor = {1'b0, lo_r} + {1'b0, s_eff};
    assign state      = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            incr    <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timer   <= '0;
            loop_r  <= 1'b0;
            lo_r    <= '0;
            hi_r    <= '0;
            step_r  <= '0;
            dwell_r <= '0;
            hold_r  <= '0;
        end else begin
            state_q <= state_n;
            incr    <= incr_n;
            en      <= en_n;
            busy    <= (state_n != IDLE);
            done    <= done_n;
            timer   <= timer_n;
            if (latch) begin
                loop_r  <= loop;
                lo_r    <= incr_lo;
                hi_r    <= incr_hi;
                step_r  <= step;
                dwell_r <= dwell;
                hold_r  <= hold;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        incr_n  = incr;
        en_n    = en;
        done_n  = 1'b0;
        timer_n = timer;
        latch   = 1'b0;
        expire  = 1'b0;

        if (state_q == IDLE) begin
            en_n = 1'b0;
            if (start && !abort) begin
                latch   = 1'b1;
                incr_n  = incr_lo;
                en_n    = 1'b1;
                timer_n = '0;
                state_n = (incr_lo < incr_hi) ? UP : HOLD;
            end
        end else if (abort) begin
            state_n = IDLE;
            en_n    = 1'b0;
            timer_n = '0;
        end else begin
            expire = (state_q == HOLD) ? (timer == h_last) : (timer == d_last);
            if (!expire) begin
                timer_n = timer + T_WIDTH'(1);
            end else begin
                timer_n = '0;
                if (state_q == UP) begin
                    if (up_sum >= {1'b0, hi_r}) begin
                        incr_n  = hi_r;
                        state_n = HOLD;
                    end else begin
                        incr_n = up_sum[D_WIDTH-1:0];
                    end
                // Down-step: finishing snaps to lo instead of stepping below it.
                end else if ({1'b0, incr} <= down_floor) begin
                    incr_n = lo_r;
                    if (loop_r) begin
                        state_n = (lo_r < hi_r) ? UP : HOLD;
                    end else begin
                        state_n = IDLE;
                        en_n    = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    incr_n  = incr - s_eff;
                    state_n = DOWN;
                end
            end
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: a per-cycle increment profile built from the sweep rules
// is compared against the DUT for fixed corner cases and randomized configurations.
module tb_sweep_ctrl;

    localparam int DW = 8;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, loop;
    logic [DW-1:0] incr_lo, incr_hi, step;
    logic [TW-1:0] dwell, hold;
    logic [DW-1:0] incr;
    logic          en, busy, done;
    logic [1:0]    state;

    int compared   = 0;
    int mismatched = 0;
    int prof[$];

    sweep_ctrl #(.D_WIDTH(DW), .T_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
        .incr_lo(incr_lo), .incr_hi(incr_hi), .step(step), .dwell(dwell), .hold(hold),
        .incr(incr), .en(en), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected incr for each busy cycle of one pass through the profile.
    task automatic build_profile(input int lo, input int hi, input int st, input int dw, input int ho);
        int s, d, h, v;
        s = (st == 0) ? 1 : st;
        d = (dw == 0) ? 1 : dw;
        h = (ho == 0) ? 1 : ho;
        prof.delete();
        if (lo < hi) begin
            v = lo;
            while (v + s < hi) begin
                repeat (d) prof.push_back(v);
                v = v + s;
            end
            repeat (d) prof.push_back(v);
            repeat (h) prof.push_back(hi);
            v = hi;
            while (v > lo + s) begin
                v = v - s;
                repeat (d) prof.push_back(v);
            end
        end else begin
            repeat (h) prof.push_back(lo);
        end
    endtask

    task automatic set_cfg(input int lo, input int hi, input int st, input int dw, input int ho, input bit lp);
        incr_lo = DW'(lo);
        incr_hi = DW'(hi);
        step    = DW'(st);
        dwell   = TW'(dw);
        hold    = TW'(ho);
        loop    = lp;
    endtask

    task automatic run_sweep(input string name, input int lo, input int hi, input int st,
                             input int dw, input int ho, input bit settle);
        int pulse;
        build_profile(lo, hi, st, dw, ho);
        set_cfg(lo, hi, st, dw, ho, 1'b0);
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse = (prof.size() >= 2) ? $urandom_range(prof.size() - 2, 0) : -1;
        for (int i = 0; i < prof.size(); i++) begin
            compared++;
            if ({incr, en, busy, done} !== {DW'(prof[i]), 3'b110}) begin
                mismatched++;
                $display("[TB] FAIL %s cycle %0d: incr=%0d en=%0b busy=%0b done=%0b, required incr=%0d en=1 busy=1 done=0",
                         name, i, incr, en, busy, done, prof[i]);
            end
            if (i == pulse) begin
                start   = 1'b1;
                incr_lo = DW'($urandom);
                incr_hi = DW'($urandom);
                step    = DW'($urandom);
                dwell   = TW'($urandom_range(9, 0));
                loop    = 1'b1;
            end else if (i == pulse + 1) begin
                start = 1'b0;
            end
            tick();
        end
        compared++;
        if ({state, incr, en, busy, done} !== {2'd0, DW'(lo), 3'b001}) begin
            mismatched++;
            $display("[TB] FAIL %s finish: state=%0d incr=%0d en=%0b busy=%0b done=%0b, required state=0 incr=%0d en=0 busy=0 done=1",
                     name, state, incr, en, busy, done, lo);
        end
        if (settle) begin
            tick();
            compared++;
            if ({state, incr, en, busy, done} !== {2'd0, DW'(lo), 3'b000}) begin
                mismatched++;
                $display("[TB] FAIL %s after-done: state=%0d incr=%0d en=%0b busy=%0b done=%0b, required state=0 incr=%0d en=0 busy=0 done=0",
                         name, state, incr, en, busy, done, lo);
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 1'b0);
        repeat (2) tick();
        compared++;
        if ({state, incr, en, busy, done} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: state=%0d incr=%0d en=%0b busy=%0b done=%0b, required all 0",
                     state, incr, en, busy, done);
        end
        rst = 1'b0;
        tick();
        set_cfg(10, 20, 5, 2, 3, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        compared++;
        if ({state, incr, en, busy} !== {2'd1, 8'd10, 2'b11}) begin
            mismatched++;
            $display("[TB] FAIL reset_pre_up: state=%0d incr=%0d en=%0b busy=%0b, required state=1 incr=10 en=1 busy=1",
                     state, incr, en, busy);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({state, incr, en, busy, done} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_async: state=%0d incr=%0d en=%0b busy=%0b done=%0b, required all 0",
                     state, incr, en, busy, done);
        end
        #2;
        rst = 1'b0;
        tick();
        compared++;
        if ({state, incr, en, busy, done} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_release: state=%0d incr=%0d en=%0b busy=%0b done=%0b, required all 0",
                     state, incr, en, busy, done);
        end
    endtask

    task automatic test_one_shot;
        int exp_seq[9] = '{10, 10, 15, 15, 20, 20, 20, 15, 15};
        int busy_cycles = 0;
        set_cfg(10, 20, 5, 2, 3, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_cycles++;
            if (i < 9) begin
                compared++;
                if ({incr, en} !== {DW'(exp_seq[i]), 1'b1}) begin
                    mismatched++;
                    $display("[TB] FAIL one_shot cycle %0d: incr=%0d en=%0b, required incr=%0d en=1",
                             i, incr, en, exp_seq[i]);
                end
            end else if (i == 9) begin
                compared++;
                if ({state, incr, en, done} !== {2'd0, 8'd10, 2'b01}) begin
                    mismatched++;
                    $display("[TB] FAIL one_shot finish: state=%0d incr=%0d en=%0b done=%0b, required state=0 incr=10 en=0 done=1",
                             state, incr, en, done);
                end
            end else if (i == 10) begin
                compared++;
                if (done !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL one_shot done_width: done=%0b, required 0", done);
                end
            end
            tick();
        end
        compared++;
        if (busy_cycles != 9) begin
            mismatched++;
            $display("[TB] FAIL one_shot busy_count: busy cycles=%0d, required 9", busy_cycles);
        end
    endtask

    task automatic test_saturation;
        run_sweep("saturate", 250, 255, 4, 1, 1, 1'b1);
        run_sweep("step_zero", 10, 14, 0, 1, 2, 1'b1);
        run_sweep("top_edge", 0, 255, 255, 0, 0, 1'b1);
    endtask

    task automatic test_loop_abort(input string name, input int lo, input int hi, input int st,
                                   input int dw, input int ho);
        int n, len;
        logic [DW-1:0] held;
        build_profile(lo, hi, st, dw, ho);
        len = prof.size();
        set_cfg(lo, hi, st, dw, ho, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 1'b0);
        n = 2 * len + $urandom_range(len - 1, 0);
        for (int i = 0; i < n; i++) begin
            compared++;
            if ({incr, en, busy, done} !== {DW'(prof[i % len]), 3'b110}) begin
                mismatched++;
                $display("[TB] FAIL %s cycle %0d: incr=%0d en=%0b busy=%0b done=%0b, required incr=%0d en=1 busy=1 done=0",
                         name, i, incr, en, busy, done, prof[i % len]);
            end
            tick();
        end
        held  = DW'(prof[n % len]);
        abort = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            compared++;
            if ({state, incr, en, busy, done} !== {2'd0, held, 3'b000}) begin
                mismatched++;
                $display("[TB] FAIL %s abort+%0d: state=%0d incr=%0d en=%0b busy=%0b done=%0b, required state=0 incr=%0d en=0 busy=0 done=0",
                         name, k, state, incr, en, busy, done, held);
            end
            abort = 1'b0;
            tick();
        end
    endtask

    task automatic test_degenerate;
        run_sweep("degenerate", 30, 20, 7, 2, 4, 1'b1);
        run_sweep("equal_lohi", 77, 77, 3, 5, 0, 1'b1);
        set_cfg(40, 90, 10, 1, 1, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        compared++;
        if ({state, incr, en, busy, done} !== {2'd0, 8'd77, 3'b000}) begin
            mismatched++;
            $display("[TB] FAIL start_with_abort: state=%0d incr=%0d en=%0b busy=%0b done=%0b, required state=0 incr=77 en=0 busy=0 done=0",
                     state, incr, en, busy, done);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        run_sweep("b2b_first", 5, 40, 12, 2, 2, 1'b0);
        run_sweep("b2b_second", 60, 61, 1, 3, 2, 1'b1);
    endtask

    task automatic test_random;
        int lo, hi, st, dw, ho;
        for (int r = 0; r < 16; r++) begin
            lo = $urandom_range(255, 0);
            hi = $urandom_range(255, 0);
            st = $urandom_range(40, 0);
            dw = $urandom_range(3, 0);
            ho = $urandom_range(5, 0);
            run_sweep($sformatf("random%0d", r), lo, hi, st, dw, ho, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_saturation();
        test_loop_abort("loop_fixed", 10, 20, 5, 2, 3);
        test_loop_abort("loop_random", $urandom_range(100, 0), $urandom_range(200, 100),
                        $urandom_range(30, 0), $urandom_range(3, 0), $urandom_range(4, 0));
        test_degenerate();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
